// File: rtl/restador_pkg.sv
// ---------------------------------------------------------------------------
// restador_pkg
//   Shared definitions for the bit-serial subtractor:
//     state_t             - FSM encoding {IDLE, SHIFT, DONE}
//     RESTADOR_WIDTH_DEF  - default operand width
//     RESTADOR_CNT_W_DEF  - bit-counter width for the default operand width
//     cnt_width()         - bit-counter width for an arbitrary operand width
//   The counter must hold values up to WIDTH, hence $clog2(WIDTH+1).
// ---------------------------------------------------------------------------
package restador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int RESTADOR_WIDTH_DEF = 8;
    localparam int RESTADOR_CNT_W_DEF = $clog2(RESTADOR_WIDTH_DEF + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/restador_fs_cell.sv
// ---------------------------------------------------------------------------
// restador_fs_cell
//   Combinational one-bit full subtractor: computes a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in from the previous (less significant) bit
//     d    out 1  difference bit
//     bout out 1  borrow out to the next (more significant) bit
// ---------------------------------------------------------------------------
module restador_fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/restador8bits_serial.sv
// ---------------------------------------------------------------------------
// restador8bits_serial
//   Bit-serial unsigned subtractor, diff = a - b, processed LSB first, one
//   bit per clock. A start accepted in IDLE captures the operands; WIDTH
//   clocks later diff/borrow are loaded and done pulses for one cycle.
//   diff/borrow hold their value until the next operation completes.
//
//   Build option: define RESTADOR_SAT_EN to clamp diff to zero whenever the
//   final borrow is 1 (borrow itself still reports 1). Timing is unchanged.
//
//   Parameters:
//     WIDTH   operand/result width and number of shift cycles (>= 2)
//   Ports:
//     clk     in  1      rising-edge clock
//     rst     in  1      synchronous reset, active-high; aborts any operation
//     start   in  1      operation request, sampled only in IDLE
//     a       in  WIDTH  minuend, captured on the accepted start edge
//     b       in  WIDTH  subtrahend, captured on the accepted start edge
//     busy    out 1      high in SHIFT and DONE
//     done    out 1      one-cycle completion pulse
//     diff    out WIDTH  registered difference
//     borrow  out 1      final borrow out of the MSB (a < b)
// ---------------------------------------------------------------------------
module restador8bits_serial
    import restador_pkg::*;
#(
    parameter int WIDTH = RESTADOR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = cnt_width(WIDTH);

`ifdef RESTADOR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Clamp at zero on underflow when saturation is compiled in.
    function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] raw,
                                                  input logic             br_out);
        return (SAT_EN && br_out) ? '0 : raw;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Partial result only needs WIDTH-1 bits: the final bit is merged in
    // combinationally on the last shift cycle.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             d_bit;
    logic             br_out;
    logic             last_bit;

    restador_fs_cell u_fs_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_out)
    );

    assign res_next = {d_bit, res_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        br    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    br  <= br_out;
                    cnt <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff   <= sat_diff(res_next, br_out);
                        borrow <= br_out;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand and partial-result shift registers (no reset needed: they are
    // always reloaded on accept before being used)
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
        end else if (state == SHIFT) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next[WIDTH-1:1];
        end
    end

endmodule

// File: tb/tb_restador8bits_serial.sv
// ---------------------------------------------------------------------------
// tb_restador8bits_serial
//   Directed bench for the bit-serial subtractor (WIDTH=8). Expected values
//   are hand-computed; saturated expectations are selected with the same
//   RESTADOR_SAT_EN macro as the design.
// ---------------------------------------------------------------------------
module tb_restador8bits_serial;

`ifdef RESTADOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    restador8bits_serial #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] raw;   // wrapped difference
        logic       br;    // expected borrow
    } vec_t;

    vec_t vecs[10];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_diff(input logic [7:0] raw, input logic br);
        return (SAT && br) ? 8'd0 : raw;
    endfunction

    // One complete operation; checks latency, result and return to idle.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic eb, input string tag);
        int  lat;
        bit  seen;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        lat  = 0;
        seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1;
                lat  = i;
            end
        end
        chk({tag, "_latency"}, lat, 8);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_borrow"}, borrow, eb);
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        int n_done;
        int last_done;
        logic [7:0] prev_diff;

        vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
        vecs[1] = '{8'd5,   8'd10,  8'd251, 1'b1};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
        vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1};
        vecs[5] = '{8'd128, 8'd127, 8'd1,   1'b0};
        vecs[6] = '{8'd1,   8'd255, 8'd2,   1'b1};
        vecs[7] = '{8'd170, 8'd85,  8'd85,  1'b0};
        vecs[8] = '{8'd85,  8'd170, 8'd171, 1'b1};
        vecs[9] = '{8'd255, 8'd0,   8'd255, 1'b0};

        rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_diff", diff, 0);
        chk("reset_borrow", borrow, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].va, vecs[i].vb, exp_diff(vecs[i].raw, vecs[i].br),
                   vecs[i].br, $sformatf("vec%0d", i));
        end

        // start re-asserted with different operands during SHIFT is ignored
        @(negedge clk);
        a = 8'd200; b = 8'd55; start = 1'b1;
        @(posedge clk);
        #1 a = 8'd1; b = 8'd2;
        repeat (6) @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("ignore_done_count", n_done, 1);
        chk("ignore_diff", diff, 145);
        chk("ignore_borrow", borrow, 0);

        // reset 4 cycles into SHIFT aborts the operation and clears outputs
        @(negedge clk);
        a = 8'd5; b = 8'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 0);
        run_op(8'd100, 8'd1, 8'd99, 1'b0, "after_abort");

        // back-to-back: start held high, one accept every 10 cycles
        prev_diff = diff;
        last_done = -1;
        @(negedge clk);
        a = 8'd170; b = 8'd85; start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("b2b_diff", diff, 85);
                if (last_done >= 0) chk("b2b_period", i - last_done, 10);
                last_done = i;
            end else begin
                chk("b2b_hold", diff, prev_diff);
            end
            prev_diff = diff;
        end
        chk("b2b_seen_done", (last_done >= 0), 1);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
